// File: rtl/cif_host.sv
// cif_host: sends a 32-bit operand bytewise, collects a 4-byte result plus flags, and scores it against expectations
module cif_host #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] exp_z,
  input  logic [4:0]  exp_flags,
  output logic        busy,
  output logic        done,
  output logic [31:0] z_got,
  output logic [4:0]  flags_got,
  output logic        match,
  output logic        timeout,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic        xmt_wrt,
  input  logic        xmt_rdy,
  output logic [7:0]  xmt_data,
  output logic        rcv_read,
  input  logic        rcv_rdy,
  input  logic [7:0]  rcv_data
);
  // Encodings chosen so the low bits give the byte index and +1 walks SEND0..CHECK
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SEND0 = 4'd4, SEND1 = 4'd5, SEND2 = 4'd6, SEND3 = 4'd7,
    RECV0 = 4'd8, RECV1 = 4'd9, RECV2 = 4'd10, RECV3 = 4'd11, RECV4 = 4'd12,
    CHECK = 4'd13
  } state_t;
  state_t      state;
  logic [31:0] x_q;
  logic [31:0] exp_z_q;
  logic [4:0]  exp_flags_q;
  logic [23:0] tmo_cnt;
  logic        sending;
  logic        receiving;
  logic        ok;
  assign sending   = state[3:2] == 2'b01;
  assign receiving = state inside {RECV0, RECV1, RECV2, RECV3, RECV4};
  assign ok        = (z_got == exp_z_q) && (flags_got == exp_flags_q);
  assign busy      = state != IDLE;
  assign xmt_wrt   = !rst && sending && xmt_rdy;
  assign rcv_read  = !rst && receiving && rcv_rdy;
  assign xmt_data  = x_q[{state[1:0], 3'b000} +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      z_got       <= '0;
      flags_got   <= '0;
      match       <= 1'b0;
      timeout     <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      tmo_cnt     <= '0;
      x_q         <= '0;
      exp_z_q     <= '0;
      exp_flags_q <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          x_q         <= x_in;
          exp_z_q     <= exp_z;
          exp_flags_q <= exp_flags;
          z_got       <= '0;
          flags_got   <= '0;
          match       <= 1'b0;
          timeout     <= 1'b0;
          tmo_cnt     <= '0;
          state       <= SEND0;
        end
      end else if (sending) begin
        if (xmt_rdy) state <= state_t'(state + 4'd1);
      end else if (receiving) begin
        if (rcv_rdy) begin
          if (state == RECV4) flags_got <= rcv_data[4:0];
          else z_got[{state[1:0], 3'b000} +: 8] <= rcv_data;
          tmo_cnt <= '0;
          state   <= state_t'(state + 4'd1);
        end else if (tmo_cnt == TIMEOUT_CYCLES - 24'd1) begin
          state   <= IDLE;
          timeout <= 1'b1;
          match   <= 1'b0;
          done    <= 1'b1;
          if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
        end else begin
          tmo_cnt <= tmo_cnt + 24'd1;
        end
      end else begin
        state <= IDLE;
        if (state == CHECK) begin
          match <= ok;
          done  <= 1'b1;
          if (ok && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
          if (!ok && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cif_host.sv
// tb_cif_host: randomized transactions against a phase-level model of the host, with a byte-queue responder
module tb_cif_host;
  logic        clk = 0, rst = 1, start = 0;
  logic [31:0] x_in = 0, exp_z = 0;
  logic [4:0]  exp_flags = 0;
  logic        xmt_rdy = 0, rcv_rdy = 0;
  logic [7:0]  rcv_data = 0;
  logic        busy, done, match, timeout, xmt_wrt, rcv_read;
  logic [31:0] z_got;
  logic [4:0]  flags_got;
  logic [15:0] pass_cnt, fail_cnt;
  logic [7:0]  xmt_data;

  cif_host #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .exp_z(exp_z), .exp_flags(exp_flags),
    .busy(busy), .done(done), .z_got(z_got), .flags_got(flags_got), .match(match),
    .timeout(timeout), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .xmt_wrt(xmt_wrt),
    .xmt_rdy(xmt_rdy), .xmt_data(xmt_data), .rcv_read(rcv_read), .rcv_rdy(rcv_rdy),
    .rcv_data(rcv_data)
  );

  always #10 clk = ~clk;

  int errors = 0, checks = 0, edges = 0, last_acc = 0, wrt_cnt = 0, done_cnt = 0;
  logic [7:0] rsp[$];
  // model: phase 0 idle, 1 sending, 2 receiving, 3 checking
  int ph = 0, k = 0, idle = 0, mpass = 0, mfail = 0;
  logic [31:0] mx = 0, mz = 0, mez = 0;
  logic [4:0]  mf = 0, mef = 0;
  logic        mm = 0, mt = 0, md = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic int sat(input int v);
    return v < 65535 ? v + 1 : v;
  endfunction

  task automatic step(input bit st, input bit xr, input bit rr, input bit rs);
    start = st; xmt_rdy = xr; rst = rs;
    rcv_rdy = rr && rsp.size() > 0;
    rcv_data = rsp.size() > 0 ? rsp[0] : 8'($urandom);
    #1;
    chk("xmt_wrt", xmt_wrt, !rs && ph == 1 && xr);
    chk("rcv_read", rcv_read, !rs && ph == 2 && rcv_rdy);
    if (!rs && ph == 1 && xr) chk("xmt_data", xmt_data, mx[8*k +: 8]);
    wrt_cnt += int'(xmt_wrt);
    @(posedge clk);
    edges++;
    md = 0;
    if (rs) begin
      ph = 0; k = 0; idle = 0; mz = 0; mf = 0; mm = 0; mt = 0; mpass = 0; mfail = 0;
    end else begin
      case (ph)
        0: if (st) begin
          mx = x_in; mez = exp_z; mef = exp_flags; mz = 0; mf = 0; mm = 0; mt = 0; ph = 1; k = 0;
        end
        1: if (xr) begin
          k++;
          if (k == 4) begin ph = 2; k = 0; idle = 0; end
        end
        2: if (rcv_rdy) begin
          if (k < 4) mz[8*k +: 8] = rcv_data; else mf = rcv_data[4:0];
          void'(rsp.pop_front());
          last_acc = edges; idle = 0; k++;
          if (k == 5) ph = 3;
        end else begin
          idle++;
          if (idle == 16) begin ph = 0; mt = 1; mm = 0; md = 1; mfail = sat(mfail); end
        end
        default: begin
          mm = (mz == mez) && (mf == mef);
          md = 1; ph = 0;
          if (mm) mpass = sat(mpass); else mfail = sat(mfail);
        end
      endcase
    end
    @(negedge clk);
    done_cnt += int'(done);
    chk("done", done, md);
    chk("busy", busy, ph != 0);
    chk("z_got", z_got, mz);
    chk("flags_got", flags_got, mf);
    chk("match", match, mm);
    chk("timeout", timeout, mt);
    chk("pass_cnt", pass_cnt, mpass);
    chk("fail_cnt", fail_cnt, mfail);
  endtask

  task automatic txn(input logic [31:0] x, input logic [31:0] ez, input logic [4:0] ef,
                     input int xp, input int rp, input bit quarter, input bit poke, output int lat);
    int s, n;
    x_in = x; exp_z = ez; exp_flags = ef;
    step(1, quarter ? (edges % 4 == 3) : pct(xp), pct(rp), 0);
    s = edges; n = 0;
    x_in = $urandom; exp_z = $urandom; exp_flags = 5'($urandom);
    while (!md && n < 400) begin
      step(poke && (n % 3 == 1), quarter ? (edges % 4 == 3) : pct(xp), pct(rp), 0);
      n++;
    end
    chk("txn_done", done, 1);
    lat = edges - s;
  endtask

  task automatic load_echo(input logic [31:0] x, input logic [7:0] fl);
    rsp.delete();
    for (int i = 0; i < 4; i++) rsp.push_back(x[8*i +: 8]);
    rsp.push_back(fl);
  endtask

  initial begin
    int lat, n, mode;
    logic [31:0] x, ez;
    logic [4:0]  ef;
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    chk("rst_busy", busy, 0);
    // loopback echo, all ready
    load_echo(32'h3F800000, 8'h03);
    wrt_cnt = 0;
    txn(32'h3F800000, 32'h3F800000, 5'h03, 100, 100, 0, 0, lat);
    chk("loop_latency", lat, 10);
    chk("loop_match", match, 1);
    chk("loop_pass", pass_cnt, 1);
    chk("loop_wrt", wrt_cnt, 4);
    // bad flags byte, upper bits ignored
    load_echo(32'h3F800000, 8'hE1);
    txn(32'h3F800000, 32'h3F800000, 5'h03, 100, 100, 0, 0, lat);
    chk("flags_e1", flags_got, 5'h01);
    chk("flags_match", match, 0);
    chk("flags_fail", fail_cnt, 1);
    // responder stops after two bytes
    rsp = '{8'h78, 8'h56};
    txn(32'h12345678, 32'h12345678, 5'h03, 100, 100, 0, 0, lat);
    chk("tmo_latency", edges - last_acc, 16);
    chk("tmo_flag", timeout, 1);
    chk("tmo_partial", z_got, 32'h00005678);
    chk("tmo_fail", fail_cnt, 2);
    // slow transmitter, start poked while busy
    load_echo(32'hCAFEF00D, 8'h03);
    wrt_cnt = 0; done_cnt = 0;
    txn(32'hCAFEF00D, 32'hCAFEF00D, 5'h03, 0, 100, 1, 1, lat);
    step(0, 0, 0, 0);
    chk("slow_wrt", wrt_cnt, 4);
    chk("slow_done", done_cnt, 1);
    chk("slow_match", match, 1);
    // reset in the middle of receive
    load_echo(32'hA5A55A5A, 8'h03);
    x_in = 32'hA5A55A5A; exp_z = 32'hA5A55A5A; exp_flags = 5'h03;
    step(1, 1, 1, 0);
    n = 0;
    while (!(ph == 2 && k == 2) && n < 50) begin step(0, 1, 1, 0); n++; end
    chk("reach_recv2", busy, 1);
    step(0, 1, 1, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pass", pass_cnt, 0);
    chk("mid_rst_fail", fail_cnt, 0);
    step(0, 1, 1, 0);
    load_echo(32'hA5A55A5A, 8'h03);
    txn(32'hA5A55A5A, 32'hA5A55A5A, 5'h03, 100, 100, 0, 0, lat);
    chk("post_rst_match", match, 1);
    chk("post_rst_pass", pass_cnt, 1);
    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      x = $urandom; ez = x; ef = 5'h03;
      mode = int'($urandom_range(3, 0));
      load_echo(x, {3'($urandom), 5'h03});
      if (mode == 1) ez = ez ^ (32'd1 << $urandom_range(31, 0));
      if (mode == 2) ef = 5'($urandom);
      if (mode == 3) begin
        n = int'($urandom_range(4, 0));
        while (rsp.size() > n) void'(rsp.pop_back());
      end
      txn(x, ez, ef, int'($urandom_range(100, 30)), int'($urandom_range(100, 60)),
          $urandom_range(3, 0) == 0, 1'($urandom), lat);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cif_host.md
CIF_HOST -- requirements
Module: cif_host

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 24'd10000000, maximum receive-wait cycles per result byte (0.2 s at 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst  input  1  reset; rst is synchronous and active-high, and clk is the clock.
REQ-004 start  input  1  request one test transaction; sampled only in IDLE.
REQ-005 x_in  input  32  operand to send.
REQ-006 exp_z  input  32  expected result.
REQ-007 exp_flags  input  5  expected flags.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 z_got  output  32  received result.
REQ-011 flags_got  output  5  received flags.
REQ-012 match  output  1  z_got==exp_z and flags_got==exp_flags.
REQ-013 timeout  output  1  last transaction aborted on receive timeout.
REQ-014 pass_cnt  output  16  count of matching transactions.
REQ-015 fail_cnt  output  16  count of mismatching or timed-out transactions.
REQ-016 xmt_wrt  output  1  write strobe to the byte transmitter.
REQ-017 xmt_rdy  input  1  transmitter can accept a byte.
REQ-018 xmt_data  output  8  byte to transmit.
REQ-019 rcv_read  output  1  read strobe to the byte receiver.
REQ-020 rcv_rdy  input  1  receiver holds a byte.
REQ-021 rcv_data  input  8  received byte.

Function
REQ-022 States: IDLE, SEND0..SEND3, RECV0..RECV4, CHECK.
REQ-023 Transition: IDLE -> SEND0 on start; on that edge, latch x_in, exp_z and exp_flags into internal registers and clear z_got, flags_got, match and timeout.
REQ-024 Transition: SENDk -> SEND(k+1) (SEND3 -> RECV0) on an edge with xmt_rdy=1; otherwise hold.
REQ-025 Transmit data: xmt_data = latched x byte k (bits 8k+7:8k), least-significant byte first; xmt_wrt = xmt_rdy in SENDk, 0 in all other states.
REQ-026 Receive data: in RECVk, rcv_read = rcv_rdy, 0 in all other states; when rcv_rdy=1, RECV0..3 write rcv_data into z_got byte k and RECV4 writes rcv_data[4:0] into flags_got (bits 7:5 ignored).
REQ-027 Transition: RECVk -> RECV(k+1) (RECV4 -> CHECK) on an edge with rcv_rdy=1.
REQ-028 Timeout counter: 24 bits; cleared on entry to SEND0 and on each accepted byte; increments each RECV cycle with rcv_rdy=0.
REQ-029 Timeout abort: when the counter reaches TIMEOUT_CYCLES-1 with rcv_rdy=0, go to IDLE, set timeout=1, match=0, pulse done, increment fail_cnt; any partially received z_got/flags_got is kept.
REQ-030 CHECK -> IDLE unconditionally: register match, pulse done, increment pass_cnt if match=1, otherwise fail_cnt.
REQ-031 Counter saturation: pass_cnt and fail_cnt saturate at 16'hFFFF.
REQ-032 Output hold: z_got, flags_got, match and timeout hold until the next accepted start.
REQ-033 Busy-state start: start is ignored in every non-IDLE state.
REQ-034 Start after done: start in the cycle done is high is accepted, since the state is IDLE.
REQ-035 Latency: with xmt_rdy=rcv_rdy=1 held, start sampled at edge E0 gives done high for exactly the cycle after E10.
REQ-036 Transmit stall: there is no timeout while transmitting; SENDk waits indefinitely on xmt_rdy.

Reset
REQ-037 rst=1 at any edge, including mid-transaction, sets state IDLE and clears busy, done, match, timeout, z_got, flags_got, pass_cnt, fail_cnt and the timeout counter.
REQ-038 During and after reset, xmt_wrt=0 and rcv_read=0 until a new start is accepted.

Verification
REQ-039 Loopback responder that echoes x (z=x, flags=5'h03); x_in=32'h3F800000, exp_z=32'h3F800000, exp_flags=5'h03 -> bytes 00,00,80,3F sent in order, done after E10, match=1, pass_cnt=1.
REQ-040 Same stimulus with responder returning flags byte 8'hE1 -> flags_got=5'h01, match=0, fail_cnt=1.
REQ-041 Responder stops after 2 result bytes, TIMEOUT_CYCLES=24'd16 -> done 16 cycles after the last accepted byte, timeout=1, z_got[15:0] valid, fail_cnt=1.
REQ-042 xmt_rdy toggled 1-in-4 cycles, start pulsed while busy -> exactly 4 xmt_wrt pulses, each coinciding with xmt_rdy=1; second start ignored; one done.
REQ-043 rst asserted while in RECV2 -> next cycle busy=0, counters 0, no strobes; a following start runs a full transaction with match=1.
